// File: rtl/fifo_uart_tx_if.sv
// Signal bundle between the FIFO read port, the UART transmitter and the serial pin.
// master is the transmitter's view; slave is the FIFO/pin side.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd;
  logic             tx;
  logic             busy;
  logic             frame_done;
  logic [15:0]      frame_count;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output fifo_rd, tx, busy, frame_done, frame_count
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  fifo_rd, tx, busy, frame_done, frame_count
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and sends each word as a UART frame:
// start bit, WIDTH data bits LSB-first, optional parity bit, one stop bit.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master bus
);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_MAX  = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, START, DATA, PARITY, STOP
  } state_t;

  state_t           state_reg, state_next;
  logic [BW-1:0]    baud_reg, baud_next;
  logic [CW-1:0]    bit_reg, bit_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic             parity_reg, parity_next;
  logic             tx_reg, tx_next;
  logic             done_reg, done_next;
  logic [15:0]      count_reg, count_next;
  logic             bit_end;
  logic             pop;

  assign bit_end = (baud_reg == BAUD_MAX);
  assign pop     = (state_reg == IDLE) && bus.enable && !bus.fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shreg_reg  <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
      done_reg   <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shreg_reg  <= shreg_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
      done_reg   <= done_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    baud_next   = bit_end ? '0 : baud_reg + 1'b1;
    bit_next    = bit_reg;
    shreg_next  = shreg_reg;
    parity_next = parity_reg;
    count_next  = count_reg;
    tx_next     = 1'b1;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (pop) state_next = FETCH;
      end
      FETCH: begin
        baud_next   = '0;
        shreg_next  = bus.fifo_data;
        parity_next = (^bus.fifo_data) ^ (PARITY_ODD != 0);
        state_next  = START;
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_next = shreg_reg >> 1;
          if (bit_reg == BIT_MAX) state_next = (PARITY_EN != 0) ? PARITY : STOP;
          else                    bit_next   = bit_reg + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          count_next = count_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state_reg) begin
      baud_next = '0;
      bit_next  = '0;
    end

    // tx is computed from the upcoming state so the registered pin lines up with it
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase

    done_next = (state_next == STOP) && (baud_next == BAUD_MAX);
  end

  assign bus.fifo_rd     = pop;
  assign bus.tx          = tx_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.frame_done  = done_reg;
  assign bus.frame_count = count_reg;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a no-parity unit fed from a small FIFO model,
// plus even- and odd-parity units sending a single 0xA5 in lockstep.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.WIDTH(8)) bus0 ();
  fifo_uart_tx_if #(.WIDTH(8)) bus1 ();
  fifo_uart_tx_if #(.WIDTH(8)) bus2 ();

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // FIFO model for dut0: data appears the cycle after a pop
  logic [7:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus0.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus0.fifo_rd) begin
      bus0.fifo_data <= fifo_mem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Single-word source shared by the two parity units
  logic p_req = 1'b0;
  logic p_taken = 1'b0;
  assign bus1.fifo_empty = !(p_req && !p_taken);
  assign bus2.fifo_empty = !(p_req && !p_taken);
  assign bus1.fifo_data  = 8'hA5;
  assign bus2.fifo_data  = 8'hA5;
  assign bus1.enable     = 1'b1;
  assign bus2.enable     = 1'b1;
  always @(posedge clk) if (bus1.fifo_rd) p_taken <= 1'b1;

  int   rd_pulses   = 0;
  int   done_pulses = 0;
  logic rd_prev     = 1'b0;
  logic rd_double   = 1'b0;
  always @(negedge clk) begin
    if (bus0.fifo_rd) rd_pulses <= rd_pulses + 1;
    if (bus0.fifo_rd && rd_prev) rd_double <= 1'b1;
    rd_prev <= bus0.fifo_rd;
    if (bus0.frame_done) done_pulses <= done_pulses + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr % 16] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Called from an idle sample; returns at the sample of the frame's last cycle.
  task automatic capture(input int gap0, input int drop_at, output logic [9:0] bits,
                         output int gap, output int done_at, output bit hold_ok,
                         output bit timed_out);
    bits = '0; gap = gap0; done_at = -1; hold_ok = 1'b1; timed_out = 1'b0;
    step();
    while (bus0.tx !== 1'b0 && gap < 300) begin
      gap++;
      step();
    end
    if (bus0.tx !== 1'b0) begin
      timed_out = 1'b1;
      return;
    end
    for (int c = 1; c <= 40; c++) begin
      if (c == drop_at) bus0.enable = 1'b0;
      if ((c - 1) % 4 == 0) bits[(c - 1) / 4] = bus0.tx;
      else if (bus0.tx !== bits[(c - 1) / 4]) hold_ok = 1'b0;
      if (bus0.frame_done === 1'b1) done_at = (done_at == -1) ? c : -2;
      if (c < 40) step();
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_bits;   // bit 0 = start bit, bit 9 = stop bit
    int         exp_count;
    int         exp_gap;    // -1: not checked
  } vec_t;

  vec_t        vecs [4];
  logic [9:0]  bits;
  logic [10:0] pb1, pb2;
  int          gap, done_at, pd1, pd2, rd_base, done_base, bad, g;
  bit          hold_ok, timed_out, ph;

  initial begin
    vecs[0] = '{8'hA5, 10'b1_1010_0101_0, 1, -1};
    vecs[1] = '{8'h01, 10'b1_0000_0001_0, 2, 2};
    vecs[2] = '{8'hFF, 10'b1_1111_1111_0, 3, 2};
    vecs[3] = '{8'h3C, 10'b1_0011_1100_0, 4, 2};

    rst = 1'b1;
    bus0.enable = 1'b0;
    repeat (3) step();
    check("reset tx", bus0.tx, 1);
    check("reset busy", bus0.busy, 0);
    check("reset fifo_rd", bus0.fifo_rd, 0);
    check("reset frame_done", bus0.frame_done, 0);
    check("reset frame_count", bus0.frame_count, 0);
    rst = 1'b0;
    step();

    // Parity units: 0xA5 has four ones -> even parity 0, odd parity 1
    p_req = 1'b1;
    g = 0;
    step();
    while (bus1.tx !== 1'b0 && g < 20) begin g++; step(); end
    check("parity start seen", bus1.tx, 0);
    pb1 = '0; pb2 = '0; ph = 1'b1; pd1 = -1; pd2 = -1;
    for (int c = 1; c <= 44; c++) begin
      if ((c - 1) % 4 == 0) begin
        pb1[(c - 1) / 4] = bus1.tx;
        pb2[(c - 1) / 4] = bus2.tx;
      end else if (bus1.tx !== pb1[(c - 1) / 4] || bus2.tx !== pb2[(c - 1) / 4]) begin
        ph = 1'b0;
      end
      if (bus1.frame_done === 1'b1 && pd1 == -1) pd1 = c;
      if (bus2.frame_done === 1'b1 && pd2 == -1) pd2 = c;
      if (c < 44) step();
    end
    check("even parity frame bits", pb1, 11'b1_0_1010_0101_0);
    check("odd parity frame bits", pb2, 11'b1_1_1010_0101_0);
    check("parity bits held 4 cycles", ph, 1);
    check("even parity frame_done cycle", pd1, 44);
    check("odd parity frame_done cycle", pd2, 44);
    step();
    check("parity frame_count", bus1.frame_count, 1);
    check("parity busy after frame", bus1.busy, 0);

    // Empty FIFO with enable toggling: nothing may happen
    rd_base = rd_pulses;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      bus0.enable = ((i % 2) == 1);
      step();
      if (bus0.fifo_rd !== 1'b0 || bus0.tx !== 1'b1 || bus0.busy !== 1'b0) bad++;
    end
    check("empty fifo idle violations", bad, 0);
    check("empty fifo pops", rd_pulses - rd_base, 0);

    // Words present but enable low: no pop
    bus0.enable = 1'b0;
    for (int i = 0; i < 4; i++) push(vecs[i].data);
    repeat (20) step();
    check("enable low pops", rd_pulses - rd_base, 0);
    check("enable low busy", bus0.busy, 0);

    bus0.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      capture(1, 0, bits, gap, done_at, hold_ok, timed_out);
      check($sformatf("frame %0d timeout", i), timed_out, 0);
      check($sformatf("frame %0d bits", i), bits, vecs[i].exp_bits);
      check($sformatf("frame %0d bit hold", i), hold_ok, 1);
      check($sformatf("frame %0d frame_done cycle", i), done_at, 40);
      if (vecs[i].exp_gap >= 0) check($sformatf("frame %0d idle gap", i), gap, vecs[i].exp_gap);
      step();
      check($sformatf("frame %0d frame_count", i), bus0.frame_count, vecs[i].exp_count);
    end
    check("burst pops", rd_pulses - rd_base, 4);
    check("burst fifo empty", bus0.fifo_empty, 1);
    check("burst busy", bus0.busy, 0);
    check("fifo_rd never back-to-back", rd_double, 0);

    // Drop enable during data bit 3 (cycles 17..20 of the frame)
    rd_base = rd_pulses;
    push(8'h5A);
    push(8'h1D);
    capture(1, 18, bits, gap, done_at, hold_ok, timed_out);
    check("drop frame timeout", timed_out, 0);
    check("drop frame bits", bits, 10'b1_0101_1010_0);
    check("drop frame_done cycle", done_at, 40);
    repeat (20) step();
    check("drop pops", rd_pulses - rd_base, 1);
    check("drop busy", bus0.busy, 0);
    check("drop tx idle", bus0.tx, 1);
    check("drop word left in fifo", bus0.fifo_empty, 0);

    // Reset asynchronously in the middle of data bit 5 (cycles 25..28) of 0x1D
    bus0.enable = 1'b1;
    g = 0;
    step();
    while (bus0.tx !== 1'b0 && g < 20) begin g++; step(); end
    check("reset frame start seen", bus0.tx, 0);
    repeat (25) step();
    check("pre-reset data bit 5", bus0.tx, 0);
    check("pre-reset frame_count", bus0.frame_count, 5);
    done_base = done_pulses;
    #2;
    rst = 1'b1;
    #1;
    check("async reset tx", bus0.tx, 1);
    check("async reset busy", bus0.busy, 0);
    check("async reset frame_count", bus0.frame_count, 0);
    check("async reset frame_done", bus0.frame_done, 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (60) step();
    check("no frame_done after reset", done_pulses - done_base, 0);
    check("post-reset frame_count", bus0.frame_count, 0);
    check("post-reset tx", bus0.tx, 1);
    check("post-reset busy", bus0.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
